// File: rtl/assoc_inst_cache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package assoc_inst_cache_pkg;

    typedef enum logic {
        ST_READY  = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    function automatic int calc_tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int calc_ways(input int asso_w);
        return 1 << asso_w;
    endfunction

    function automatic int calc_block_size(input int offset_w);
        return 1 << offset_w;
    endfunction

endpackage

// File: rtl/assoc_inst_cache_victim_sel.sv
// Victim chooser: lowest-index invalid way of the set, else the set's round-robin pointer.
module icache_victim_sel
    import assoc_inst_cache_pkg::*;
#(
    parameter int ASSO_WIDTH = 1,
    parameter int WAYS       = calc_ways(ASSO_WIDTH)
) (
    input  logic [WAYS-1:0]       valid_vec,
    input  logic [ASSO_WIDTH-1:0] rr,
    output logic [ASSO_WIDTH-1:0] victim
);

    // Scanning downwards lets the lowest invalid way win.
    always_comb begin
        victim = rr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) victim = ASSO_WIDTH'(w);
        end
    end

endmodule

// File: rtl/assoc_inst_cache.sv
// N-way set-associative read-only instruction cache with burst refill,
// early restart, flush, refill-error response and saturating hit/miss counters.
module assoc_inst_cache
    import assoc_inst_cache_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 16,
    parameter int ASSO_WIDTH         = 1,
    parameter int INDEX_WIDTH        = 3,
    parameter int BLOCK_OFFSET_WIDTH = 5,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_read,
    input  logic                  mem_read_valid,
    input  logic                  mem_last,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    localparam int TAG_WIDTH  = calc_tag_width(ADDR_WIDTH, INDEX_WIDTH, BLOCK_OFFSET_WIDTH);
    localparam int WAYS       = calc_ways(ASSO_WIDTH);
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int BLOCK_SIZE = calc_block_size(BLOCK_OFFSET_WIDTH);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e                        state_q, state_d;
    logic [WAYS-1:0]               valid_q [SETS];
    logic [WAYS-1:0]               valid_d [SETS];
    logic [TAG_WIDTH-1:0]          tag_q   [SETS][WAYS];
    logic [TAG_WIDTH-1:0]          tag_d   [SETS][WAYS];
    logic [ASSO_WIDTH-1:0]         rr_q    [SETS];
    logic [ASSO_WIDTH-1:0]         rr_d    [SETS];
    logic [DATA_WIDTH-1:0]         blocks_q [SETS][WAYS][BLOCK_SIZE];

    logic [TAG_WIDTH-1:0]          cap_tag_q, cap_tag_d;
    logic [INDEX_WIDTH-1:0]        cap_idx_q, cap_idx_d;
    logic [BLOCK_OFFSET_WIDTH-1:0] cap_off_q, cap_off_d;
    logic [ASSO_WIDTH-1:0]         cap_way_q, cap_way_d;
    logic [BLOCK_OFFSET_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                          flush_pend_q, flush_pend_d;
    logic                          resp_valid_q, resp_valid_d;
    logic                          resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0]         resp_data_q, resp_data_d;
    logic [CNT_WIDTH-1:0]          hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]          miss_cnt_q, miss_cnt_d;

    logic [TAG_WIDTH-1:0]          req_tag;
    logic [INDEX_WIDTH-1:0]        req_idx;
    logic [BLOCK_OFFSET_WIDTH-1:0] req_off;
    logic                          hit;
    logic [ASSO_WIDTH-1:0]         hit_way;
    logic [ASSO_WIDTH-1:0]         victim_way;
    logic                          accept, beat, done, do_flush;

    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_idx  = req_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_off  = req_addr[BLOCK_OFFSET_WIDTH-1:0];
    assign accept   = req_valid && req_ready;
    assign beat     = (state_q == ST_REFILL) && mem_read_valid;
    assign done     = beat && mem_last;
    assign do_flush = flush_pend_q || flush;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = ASSO_WIDTH'(w);
            end
        end
    end

    icache_victim_sel #(
        .ASSO_WIDTH (ASSO_WIDTH),
        .WAYS       (WAYS)
    ) u_victim_sel (
        .valid_vec (valid_q[req_idx]),
        .rr        (rr_q[req_idx]),
        .victim    (victim_way)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_READY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY:  if (accept && !hit) state_d = ST_REFILL;
            ST_REFILL: if (done)           state_d = ST_READY;
            default:                       state_d = ST_READY;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_READY) && !flush && !flush_pend_q;
        mem_req   = (state_q == ST_REFILL);
        mem_addr  = mem_req ? {cap_tag_q, cap_idx_q, {BLOCK_OFFSET_WIDTH{1'b0}}} : '0;
    end

    always_comb begin
        valid_d      = valid_q;
        tag_d        = tag_q;
        rr_d         = rr_q;
        cap_tag_d    = cap_tag_q;
        cap_idx_d    = cap_idx_q;
        cap_off_d    = cap_off_q;
        cap_way_d    = cap_way_q;
        beat_cnt_d   = beat_cnt_q;
        flush_pend_d = flush_pend_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = resp_data_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        if ((state_q == ST_READY) && flush) begin
            for (int s = 0; s < SETS; s++) valid_d[s] = '0;
        end

        if (accept) begin
            if (hit) begin
                resp_valid_d = 1'b1;
                resp_data_d  = blocks_q[req_idx][hit_way][req_off];
                hit_cnt_d    = sat_inc(hit_cnt_q);
            end else begin
                cap_tag_d  = req_tag;
                cap_idx_d  = req_idx;
                cap_off_d  = req_off;
                cap_way_d  = victim_way;
                beat_cnt_d = '0;
                miss_cnt_d = sat_inc(miss_cnt_q);
                // The victim goes invalid now so a half-written line can never hit.
                valid_d[req_idx][victim_way] = 1'b0;
            end
        end

        if ((state_q == ST_REFILL) && flush) flush_pend_d = 1'b1;

        if (beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_q == cap_off_q) begin
                resp_valid_d = 1'b1;
                resp_data_d  = mem_read;
            end
            if (mem_last) begin
                flush_pend_d = 1'b0;
                if (&beat_cnt_q) begin
                    rr_d[cap_idx_q] = rr_q[cap_idx_q] + 1'b1;
                    if (!do_flush) begin
                        valid_d[cap_idx_q][cap_way_q] = 1'b1;
                        tag_d[cap_idx_q][cap_way_q]   = cap_tag_q;
                    end
                end else if (beat_cnt_q < cap_off_q) begin
                    // Burst ended before the requested word arrived.
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                end
                if (do_flush) begin
                    for (int s = 0; s < SETS; s++) valid_d[s] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
                for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
            end
            cap_tag_q    <= '0;
            cap_idx_q    <= '0;
            cap_off_q    <= '0;
            cap_way_q    <= '0;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            rr_q         <= rr_d;
            cap_tag_q    <= cap_tag_d;
            cap_idx_q    <= cap_idx_d;
            cap_off_q    <= cap_off_d;
            cap_way_q    <= cap_way_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Line storage carries no reset; valid bits alone decide whether it is used.
    always_ff @(posedge clk) begin
        if (beat && !rst) blocks_q[cap_idx_q][cap_way_q][beat_cnt_q] <= mem_read;
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_assoc_inst_cache.sv
// Directed bench for assoc_inst_cache with a line-table reference model checked every cycle.
module tb_assoc_inst_cache;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CW = 6;
    localparam int SETS = 8;
    localparam int WAYS = 2;
    localparam int BS = 32;
    localparam int CNT_MAX = 63;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          flush;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_read;
    logic          mem_read_valid;
    logic          mem_last;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    assoc_inst_cache #(
        .DATA_WIDTH         (DW),
        .ADDR_WIDTH         (AW),
        .ASSO_WIDTH         (1),
        .INDEX_WIDTH        (3),
        .BLOCK_OFFSET_WIDTH (5),
        .CNT_WIDTH          (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .flush          (flush),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_read_valid (mem_read_valid),
        .mem_last       (mem_last),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memword(input int a);
        logic [15:0] lo;
        lo = a[15:0];
        return {16'hC0DE, lo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a table of resident lines plus one outstanding miss.
    bit   m_valid [SETS][WAYS];
    int   m_tag   [SETS][WAYS];
    int   m_rr    [SETS];
    bit   m_busy, m_pflush;
    int   m_addr, m_way, m_beats, m_hits, m_miss;
    bit   exp_rv, exp_re;
    logic [DW-1:0] exp_rd;

    always @(posedge clk) begin : model
        int a, set, tag, hw;
        exp_rv = 1'b0;
        exp_re = 1'b0;
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                m_rr[s] = 0;
                for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
            end
            m_busy = 1'b0; m_pflush = 1'b0; m_hits = 0; m_miss = 0; exp_rd = '0;
        end else if (!m_busy) begin
            if (flush) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
            end else if (req_valid) begin
                a = int'(req_addr);
                set = (a / BS) % SETS;
                tag = a / (BS * SETS);
                hw = -1;
                for (int w = 0; w < WAYS; w++)
                    if (m_valid[set][w] && m_tag[set][w] == tag) hw = w;
                if (hw >= 0) begin
                    exp_rv = 1'b1;
                    exp_rd = memword(a);
                    if (m_hits < CNT_MAX) m_hits++;
                end else begin
                    if (m_miss < CNT_MAX) m_miss++;
                    m_busy = 1'b1; m_pflush = 1'b0; m_addr = a; m_beats = 0;
                    m_way = -1;
                    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[set][w]) m_way = w;
                    if (m_way < 0) m_way = m_rr[set];
                    m_valid[set][m_way] = 1'b0;
                end
            end
        end else begin
            if (flush) m_pflush = 1'b1;
            if (mem_read_valid) begin
                if (m_beats == m_addr % BS) begin
                    exp_rv = 1'b1;
                    exp_rd = memword(m_addr);
                end
                m_beats++;
                if (mem_last) begin
                    m_busy = 1'b0;
                    set = (m_addr / BS) % SETS;
                    if (m_beats == BS) begin
                        m_rr[set] = (m_rr[set] + 1) % WAYS;
                        if (!m_pflush) begin
                            m_valid[set][m_way] = 1'b1;
                            m_tag[set][m_way] = m_addr / (BS * SETS);
                        end
                    end else if (m_beats <= m_addr % BS) begin
                        exp_rv = 1'b1; exp_re = 1'b1; exp_rd = '0;
                    end
                    if (m_pflush)
                        for (int s = 0; s < SETS; s++)
                            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
                    m_pflush = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(!m_busy && !flush && !m_pflush));
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("resp_err", 32'(resp_err), 32'(exp_re));
                chk("resp_data", resp_data, exp_rd);
            end
            chk("mem_req", 32'(mem_req), 32'(m_busy));
            chk("mem_addr", 32'(mem_addr), m_busy ? 32'(m_addr - m_addr % BS) : 32'd0);
            chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
            chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int a);
        req_valid = 1'b1;
        req_addr  = AW'(a);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic burst(input int base, input int nbeats, input bit gaps, input int flush_beat);
        int waited;
        waited = 0;
        while (!mem_req && waited < 20) begin
            tick();
            waited++;
        end
        if (!mem_req) chk("burst_start_timeout", 32'(mem_req), 32'd1);
        for (int b = 0; b < nbeats; b++) begin
            mem_read_valid = 1'b1;
            mem_read       = memword(base + b);
            mem_last       = (b == nbeats - 1);
            flush          = (b == flush_beat);
            tick();
            flush = 1'b0; mem_read_valid = 1'b0; mem_last = 1'b0;
            if (gaps && (b % 3 == 1) && b != nbeats - 1) tick();
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        mem_read = '0; mem_read_valid = 1'b0; mem_last = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // First miss with early restart on beat 3.
        request(16'h0123);
        chk("miss_mem_req", 32'(mem_req), 32'd1);
        chk("miss_mem_addr", 32'(mem_addr), 32'h0120);
        for (int b = 0; b < BS; b++) begin
            mem_read_valid = 1'b1;
            mem_read       = memword(16'h0120 + b);
            mem_last       = (b == BS - 1);
            tick();
            if (b == 3) begin
                chk("early_restart_valid", 32'(resp_valid), 32'd1);
                chk("early_restart_data", resp_data, 32'hC0DE0123);
            end
        end
        mem_read_valid = 1'b0; mem_last = 1'b0;
        chk("fill_done_mem_req", 32'(mem_req), 32'd0);
        chk("fill_done_ready", 32'(req_ready), 32'd1);

        // 32 back-to-back hits.
        for (int i = 0; i < BS; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(16'h0120 + i);
            tick();
        end
        req_valid = 1'b0;
        chk("b2b_last_data", resp_data, 32'hC0DE013F);
        chk("hit_cnt_32", 32'(hit_cnt), 32'd32);
        chk("miss_cnt_1", 32'(miss_cnt), 32'd1);

        // Second way of set 1, then a third tag evicts way 0 by round robin.
        request(16'h0220); burst(16'h0220, BS, 1'b0, -1);
        request(16'h0320); burst(16'h0320, BS, 1'b0, -1);
        request(16'h0220);
        chk("survivor_hit_valid", 32'(resp_valid), 32'd1);
        chk("survivor_hit_data", resp_data, 32'hC0DE0220);
        request(16'h0120);
        chk("evicted_miss", 32'(mem_req), 32'd1);
        burst(16'h0120, BS, 1'b0, -1);

        // Flush in READY blocks the held request for one cycle only.
        req_valid = 1'b1; req_addr = 16'h0123; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_blocks_accept", 32'(mem_req), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("held_req_accepted", 32'(mem_req), 32'd1);
        burst(16'h0120, BS, 1'b1, 10);
        request(16'h0123);
        chk("after_pending_flush_miss", 32'(mem_req), 32'd1);
        burst(16'h0120, BS, 1'b1, -1);

        // A stray beat outside REFILL changes nothing.
        mem_read_valid = 1'b1; mem_last = 1'b1; mem_read = 32'hDEADBEEF;
        tick();
        mem_read_valid = 1'b0; mem_last = 1'b0;
        request(16'h0123);
        chk("stray_beat_hit", 32'(resp_valid), 32'd1);

        // Drive the 6-bit hit counter into saturation.
        for (int i = 0; i < 40; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(16'h0120 + (i % BS));
            tick();
        end
        req_valid = 1'b0;
        chk("hit_cnt_saturated", 32'(hit_cnt), 32'd63);
        chk("miss_cnt_6", 32'(miss_cnt), 32'd6);

        // Early mem_last before the requested word.
        flush = 1'b1; tick(); flush = 1'b0;
        request(16'h0123);
        burst(16'h0120, 3, 1'b0, -1);
        chk("err_valid", 32'(resp_valid), 32'd1);
        chk("err_flag", 32'(resp_err), 32'd1);
        chk("err_data", resp_data, 32'd0);
        request(16'h0123);
        chk("err_line_invalid", 32'(mem_req), 32'd1);

        // Reset in the middle of a burst.
        for (int b = 0; b <= 10; b++) begin
            mem_read_valid = 1'b1;
            mem_read       = memword(16'h0120 + b);
            rst            = (b == 10);
            tick();
        end
        mem_read_valid = 1'b0;
        chk("rst_burst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_burst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_burst_miss_cnt", 32'(miss_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_burst_ready", 32'(req_ready), 32'd1);
        request(16'h0123);
        chk("post_rst_miss", 32'(mem_req), 32'd1);
        burst(16'h0120, BS, 1'b0, -1);
        request(16'h013A);
        chk("post_rst_hit_data", resp_data, 32'hC0DE013A);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
